ias_fetch_unit: RTL and testbench

//  IAS instruction-fetch stage. Reads 40-bit words from memory, splits each into left/right 20-bit

---
 rtl/ias_fetch_unit.sv | 132 +++++++++++++
 tb/tb_ias_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ias_fetch_unit.sv
// IAS instruction-fetch stage: fetches 40-bit words, splits them into left/right
// instructions and issues them in order, with redirect support for jumps.
module ias_fetch_unit #(
  parameter int unsigned WORD_W = 40,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OP_W-1:0]   instr_opcode,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_right,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              redirect_right,
  output logic              busy
);

  localparam int unsigned HALF_W = WORD_W / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SPLIT,
    S_ISSUE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [WORD_W-1:0]   mbr;
  logic [HALF_W-1:0]   ibr;
  logic                ibr_valid;
  logic                start_right;
  logic                handshake;

  assign handshake = instr_valid & instr_ready;
  assign mem_addr  = pc;
  assign instr_pc  = pc;

  // Fetch/split/issue sequencer; redirect overrides everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      mbr          <= '0;
      ibr          <= '0;
      ibr_valid    <= 1'b0;
      start_right  <= 1'b0;
      mem_req      <= 1'b0;
      instr_valid  <= 1'b0;
      instr_opcode <= '0;
      instr_addr   <= '0;
      instr_right  <= 1'b0;
      busy         <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_addr;
      start_right <= redirect_right;
      ibr_valid   <= 1'b0;
      state       <= S_FETCH;
      mem_req     <= 1'b1;
      instr_valid <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            mbr     <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          if (start_right) begin
            instr_opcode <= mbr[HALF_W-1 -: OP_W];
            instr_addr   <= mbr[ADDR_W-1:0];
            ibr_valid    <= 1'b0;
            instr_right  <= 1'b1;
            start_right  <= 1'b0;
          end else begin
            instr_opcode <= mbr[WORD_W-1 -: OP_W];
            instr_addr   <= mbr[HALF_W+ADDR_W-1 -: ADDR_W];
            ibr          <= mbr[HALF_W-1:0];
            ibr_valid    <= 1'b1;
            instr_right  <= 1'b0;
          end
          instr_valid <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (handshake) begin
            // Left accepted with a buffered right half: issue it next cycle, no bubble.
            if (!instr_right && ibr_valid) begin
              instr_opcode <= ibr[HALF_W-1 -: OP_W];
              instr_addr   <= ibr[ADDR_W-1:0];
              ibr_valid    <= 1'b0;
              instr_right  <= 1'b1;
            end else begin
              pc          <= pc + ADDR_W'(1);
              instr_valid <= 1'b0;
              if (run) begin
                state   <= S_FETCH;
                mem_req <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Bench for ias_fetch_unit: memory responder model plus an in-order scoreboard of
// expected instructions, driven from a vector table and short directed sequences.
module tb_ias_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [39:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [11:0] instr_addr;
  logic [11:0] instr_pc;
  logic        instr_right;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        redirect_right;
  logic        busy;

  ias_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_addr     (instr_addr),
    .instr_pc       (instr_pc),
    .instr_right    (instr_right),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .redirect_right (redirect_right),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [11:0] addr;
    logic [11:0] pc;
    logic        right;
    int          stall;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [39:0] word;
    int          stall_l;
    int          stall_r;
  } vec_t;

  logic [39:0] mem [4096];
  exp_t        q[$];
  int          hs_cyc[$];
  vec_t        tbl[4];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          stall_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_redir = 1'b0;
  logic        prev_rstn = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [11:0] a, input logic [39:0] w,
                           input int stall_l, input int stall_r);
    q.push_back('{op: w[39:32], addr: w[31:20], pc: a, right: 1'b0, stall: stall_l});
    q.push_back('{op: w[19:12], addr: w[11:0],  pc: a, right: 1'b1, stall: stall_r});
  endtask

  // One clock cycle: memory response, protocol/scoreboard checks, then the edge.
  task automatic tick();
    exp_t e;
    if (mem_req && wait_cnt >= mem_wait) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 40'({$urandom(), $urandom()});
    end
    if (mem_req && !mem_ack) wait_cnt++;
    else wait_cnt = 0;

    if (prev_rstn && prev_req && !prev_ack && !prev_redir)
      chk("mem_req_held", 64'(mem_req), 64'(1));
    if (mem_req && q.size() > 0)
      chk("mem_addr", 64'(mem_addr), 64'(q[0].pc));

    if (instr_valid && !instr_ready && !redirect_valid && q.size() > 0) begin
      chk("stall_no_req", 64'(mem_req), 64'(0));
      chk("stall_op",     64'(instr_opcode), 64'(q[0].op));
      chk("stall_addr",   64'(instr_addr), 64'(q[0].addr));
      chk("stall_pc",     64'(instr_pc), 64'(q[0].pc));
    end

    if (instr_valid && instr_ready && !redirect_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: op %0h addr %0h pc %0h right %0b, none expected",
                 instr_opcode, instr_addr, instr_pc, instr_right);
      end else begin
        e = q.pop_front();
        chk("issue_op",    64'(instr_opcode), 64'(e.op));
        chk("issue_addr",  64'(instr_addr), 64'(e.addr));
        chk("issue_pc",    64'(instr_pc), 64'(e.pc));
        chk("issue_right", 64'(instr_right), 64'(e.right));
      end
      hs_cyc.push_back(cyc);
      stall_cnt = 0;
    end

    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_redir = redirect_valid;
    prev_rstn  = rst_n;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run until every expected instruction is issued; run drops once the last word is in flight.
  task automatic drain(input int max_cycles);
    int n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      if (q.size() <= 2) run = 1'b0;
      if (instr_valid && stall_cnt < q[0].stall) begin
        instr_ready = 1'b0;
        stall_cnt++;
      end else begin
        instr_ready = 1'b1;
      end
      tick();
      n++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d instructions pending after %0d cycles", q.size(), n);
      q.delete();
    end
    instr_ready = 1'b0;
    stall_cnt   = 0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    instr_ready = 1'b0;
    while (!instr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid: instr_valid still 0 after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    tbl[0] = '{addr: 12'h000, word: 40'h01_00A_02_00B, stall_l: 0, stall_r: 0};
    tbl[1] = '{addr: 12'h001, word: 40'hA5_FFF_5A_000, stall_l: 0, stall_r: 0};
    tbl[2] = '{addr: 12'h002, word: 40'h3C_123_C3_321, stall_l: 5, stall_r: 0};
    tbl[3] = '{addr: 12'h003, word: 40'hFF_800_00_7FF, stall_l: 0, stall_r: 2};

    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; redirect_right = 1'b0;

    // Reset with mem_ack toggling
    for (int i = 0; i < 2; i++) begin
      mem_ack   = (i == 0);
      mem_rdata = 40'({$urandom(), $urandom()});
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_valid",   64'(instr_valid), 64'(0));
    chk("rst_right",   64'(instr_right), 64'(0));
    chk("rst_busy",    64'(busy), 64'(0));
    chk("rst_addr",    64'(mem_addr), 64'(0));
    chk("rst_op",      64'(instr_opcode), 64'(0));
    chk("rst_iaddr",   64'(instr_addr), 64'(0));
    rst_n = 1'b1;
    tick();

    // Sequential words from the table, with backpressure on some halves
    foreach (tbl[i]) begin
      mem[tbl[i].addr] = tbl[i].word;
      push_word(tbl[i].addr, tbl[i].word, tbl[i].stall_l, tbl[i].stall_r);
    end
    hs_cyc.delete();
    run = 1'b1;
    drain(200);
    chk("b2b_left_right", 64'(hs_cyc[1] - hs_cyc[0]), 64'(1));
    chk("pair_period",    64'(hs_cyc[2] - hs_cyc[0]), 64'(4));
    repeat (3) tick();
    chk("tbl_end_busy", 64'(busy), 64'(0));
    chk("tbl_end_req",  64'(mem_req), 64'(0));
    chk("tbl_end_pc",   64'(mem_addr), 64'(12'h004));

    // Redirect while a right half is buffered and execute is ready
    mem[12'h004] = 40'h11_111_22_222;
    mem[12'h123] = 40'h77_456_88_789;
    run = 1'b1;
    wait_valid(20);
    chk("redir_pre_op",    64'(instr_opcode), 64'(8'h11));
    chk("redir_pre_right", 64'(instr_right), 64'(0));
    redirect_valid = 1'b1; redirect_addr = 12'h123; redirect_right = 1'b1; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("redir_valid_drop", 64'(instr_valid), 64'(0));
    chk("redir_req",        64'(mem_req), 64'(1));
    chk("redir_addr",       64'(mem_addr), 64'(12'h123));
    q.push_back('{op: 8'h88, addr: 12'h789, pc: 12'h123, right: 1'b1, stall: 0});
    drain(30);
    repeat (2) tick();
    chk("redir_next_pc", 64'(mem_addr), 64'(12'h124));
    chk("redir_busy",    64'(busy), 64'(0));

    // PC wrap with a slow memory
    mem[12'hFFF] = 40'hDE_ABC_AD_CBA;
    mem_wait = 3;
    redirect_valid = 1'b1; redirect_addr = 12'hFFF; redirect_right = 1'b0;
    tick();
    redirect_valid = 1'b0;
    push_word(12'hFFF, 40'hDE_ABC_AD_CBA, 0, 0);
    drain(40);
    repeat (2) tick();
    mem_wait = 0;
    chk("wrap_pc",   64'(mem_addr), 64'(12'h000));
    chk("wrap_busy", 64'(busy), 64'(0));

    // run dropped while the left half is waiting
    push_word(12'h000, tbl[0].word, 2, 0);
    run = 1'b1;
    tick();
    wait_valid(20);
    run = 1'b0;
    drain(30);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("park_no_req", 64'(mem_req), 64'(0));
    end
    chk("park_busy", 64'(busy), 64'(0));
    chk("park_pc",   64'(mem_addr), 64'(12'h001));

    // Reset in the middle of a fetch
    mem_wait = 10;
    run = 1'b1;
    tick();
    tick();
    chk("midrst_req_before", 64'(mem_req), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b0; mem_wait = 0;
    tick();
    chk("midrst_req",   64'(mem_req), 64'(0));
    chk("midrst_busy",  64'(busy), 64'(0));
    chk("midrst_valid", 64'(instr_valid), 64'(0));
    chk("midrst_pc",    64'(mem_addr), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
